isp_cfg_sched: RTL and testbench

- Frame-synchronous configuration scheduler for the DPC→BNR raw ISP chain in the HDMI output path.
- Accepts configuration requests from a host or register block through a req/ack handshake, and holds each request in shadow registers.
- Commits the shadow values to the live DPC threshold, BNR noise-reduction level and stage bypass controls only on a frame boundary.
- Then masks the output for a programmable number of frames so that stale line-buffer contents never reach the display.

---
 rtl/isp_cfg_sched.sv | 180 ++++++++++++++++++
 tb/tb_isp_cfg_sched.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/isp_cfg_sched.sv
// Frame-synchronous configuration scheduler for the DPC->BNR raw ISP chain.
// A request is captured into shadow registers and committed to the live
// controls only at a vsync rising edge (or by watchdog). The video is then
// masked for a programmable number of frames before the request is acked.
module isp_cfg_sched #(
  parameter int THR_BITS       = 16,
  parameter int NR_BITS        = 3,
  parameter int DEF_THR        = 0,
  parameter int DEF_NR         = 0,
  parameter int SETTLE_FRAMES  = 2,
  parameter int TIMEOUT_CYCLES = 4194304,
  parameter int FCNT_BITS      = 16
) (
  input  logic                 pclk,
  input  logic                 rst_n,
  input  logic                 in_vsync,
  input  logic                 cfg_req,
  input  logic [THR_BITS-1:0]  cfg_thr,
  input  logic [NR_BITS-1:0]   cfg_nr,
  input  logic                 cfg_dpc_byp,
  input  logic                 cfg_bnr_byp,
  output logic                 cfg_busy,
  output logic                 cfg_ack,
  output logic [THR_BITS-1:0]  dpc_threshold,
  output logic [NR_BITS-1:0]   bnr_nr_level,
  output logic                 dpc_bypass,
  output logic                 bnr_bypass,
  output logic                 out_mask,
  output logic                 frame_start,
  output logic [FCNT_BITS-1:0] frame_cnt,
  output logic                 vs_timeout
);

  // Watchdog must hold values up to TIMEOUT_CYCLES-1 without wrapping.
  localparam int WD_BITS = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_PEND   = 2'd1,
    S_SETTLE = 2'd2
  } state_t;

  state_t               state_q, state_d;

  logic                 vs_d_q;
  logic                 vs_edge;
  logic                 frame_start_q;
  logic [FCNT_BITS-1:0] frame_cnt_q;

  logic [THR_BITS-1:0]  sh_thr_q, thr_q;
  logic [NR_BITS-1:0]   sh_nr_q, nr_q;
  logic                 sh_dbyp_q, dbyp_q;
  logic                 sh_bbyp_q, bbyp_q;

  logic                 mask_q;
  logic                 ack_q;
  logic                 timeout_q;
  logic [3:0]           settle_q;
  logic [WD_BITS-1:0]   wd_q;
  logic                 wd_hit;

  logic                 capture;
  logic                 commit;
  logic                 settle_done;
  logic                 settle_dec;

  assign vs_edge = in_vsync & ~vs_d_q;
  assign wd_hit  = (wd_q == WD_BITS'(TIMEOUT_CYCLES - 1));

  // State register.
  always_ff @(posedge pclk) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state: capture -> wait for frame boundary -> mask frames -> idle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (cfg_req)              state_d = S_PEND;
      S_PEND:   if (vs_edge || wd_hit)    state_d = S_SETTLE;
      S_SETTLE: if (settle_q == 4'd0)     state_d = S_IDLE;
      default:                            state_d = S_IDLE;
    endcase
  end

  // Per-state control strobes; the zero-count exit wins over a coincident edge.
  always_comb begin
    cfg_busy    = (state_q != S_IDLE);
    capture     = (state_q == S_IDLE) && cfg_req;
    commit      = (state_q == S_PEND) && (vs_edge || wd_hit);
    settle_done = (state_q == S_SETTLE) && (settle_q == 4'd0);
    settle_dec  = (state_q == S_SETTLE) && (settle_q != 4'd0) && vs_edge;
  end

  // Vsync history, frame-start pulse and wrapping frame counter.
  always_ff @(posedge pclk) begin
    if (!rst_n) begin
      vs_d_q        <= 1'b0;
      frame_start_q <= 1'b0;
      frame_cnt_q   <= '0;
    end else begin
      vs_d_q        <= in_vsync;
      frame_start_q <= vs_edge;
      if (vs_edge) frame_cnt_q <= frame_cnt_q + FCNT_BITS'(1);
    end
  end

  // Shadow copy of the request, loaded only when the block is idle.
  always_ff @(posedge pclk) begin
    if (!rst_n) begin
      sh_thr_q  <= '0;
      sh_nr_q   <= '0;
      sh_dbyp_q <= 1'b0;
      sh_bbyp_q <= 1'b0;
    end else if (capture) begin
      sh_thr_q  <= cfg_thr;
      sh_nr_q   <= cfg_nr;
      sh_dbyp_q <= cfg_dpc_byp;
      sh_bbyp_q <= cfg_bnr_byp;
    end
  end

  // Live controls move only at a commit so a frame never sees a mixed config.
  always_ff @(posedge pclk) begin
    if (!rst_n) begin
      thr_q  <= THR_BITS'(DEF_THR);
      nr_q   <= NR_BITS'(DEF_NR);
      dbyp_q <= 1'b0;
      bbyp_q <= 1'b0;
    end else if (commit) begin
      thr_q  <= sh_thr_q;
      nr_q   <= sh_nr_q;
      dbyp_q <= sh_dbyp_q;
      bbyp_q <= sh_bbyp_q;
    end
  end

  // Output mask, settle frame count and the one-cycle ack.
  always_ff @(posedge pclk) begin
    if (!rst_n) begin
      mask_q   <= 1'b0;
      settle_q <= 4'd0;
      ack_q    <= 1'b0;
    end else begin
      ack_q <= settle_done;
      if (commit) begin
        mask_q   <= 1'b1;
        settle_q <= 4'(SETTLE_FRAMES);
      end else if (settle_done) begin
        mask_q   <= 1'b0;
      end else if (settle_dec) begin
        settle_q <= settle_q - 4'd1;
      end
    end
  end

  // Watchdog counts only while waiting for a frame boundary; sticky flag on expiry.
  always_ff @(posedge pclk) begin
    if (!rst_n) begin
      wd_q      <= '0;
      timeout_q <= 1'b0;
    end else begin
      if (state_q == S_PEND) wd_q <= wd_q + WD_BITS'(1);
      else                   wd_q <= '0;
      if (commit && !vs_edge) timeout_q <= 1'b1;
    end
  end

  assign cfg_ack       = ack_q;
  assign dpc_threshold = thr_q;
  assign bnr_nr_level  = nr_q;
  assign dpc_bypass    = dbyp_q;
  assign bnr_bypass    = bbyp_q;
  assign out_mask      = mask_q;
  assign frame_start   = frame_start_q;
  assign frame_cnt     = frame_cnt_q;
  assign vs_timeout    = timeout_q;

endmodule

// File: tb/tb_isp_cfg_sched.sv
// Randomized scoreboard bench for isp_cfg_sched. Two instances share one
// stimulus stream: one with 2 settle frames, one with 0. The whole vsync and
// reset timeline is drawn up front, so each accepted request's commit and ack
// cycles are predicted from that timeline when the request is issued.
`timescale 1ns/1ps
module tb_isp_cfg_sched;
  localparam int N    = 8000;
  localparam int TW   = 16;
  localparam int NW   = 3;
  localparam int FW   = 4;
  localparam int TO   = 100;
  localparam int HUGE = 1 << 30;

  logic          pclk = 1'b0;
  logic          rst_n, in_vsync, cfg_req, cfg_dpc_byp, cfg_bnr_byp;
  logic [TW-1:0] cfg_thr;
  logic [NW-1:0] cfg_nr;

  logic          busy [2], ack [2], dbyp [2], bbyp [2], mask [2], fs [2], tof [2];
  logic [TW-1:0] thr [2];
  logic [NW-1:0] nr [2];
  logic [FW-1:0] fc [2];

  always #5 pclk = ~pclk;

  isp_cfg_sched #(.THR_BITS(TW), .NR_BITS(NW), .SETTLE_FRAMES(2),
                  .TIMEOUT_CYCLES(TO), .FCNT_BITS(FW)) u_s2 (
    .pclk(pclk), .rst_n(rst_n), .in_vsync(in_vsync), .cfg_req(cfg_req),
    .cfg_thr(cfg_thr), .cfg_nr(cfg_nr), .cfg_dpc_byp(cfg_dpc_byp),
    .cfg_bnr_byp(cfg_bnr_byp), .cfg_busy(busy[0]), .cfg_ack(ack[0]),
    .dpc_threshold(thr[0]), .bnr_nr_level(nr[0]), .dpc_bypass(dbyp[0]),
    .bnr_bypass(bbyp[0]), .out_mask(mask[0]), .frame_start(fs[0]),
    .frame_cnt(fc[0]), .vs_timeout(tof[0]));

  isp_cfg_sched #(.THR_BITS(TW), .NR_BITS(NW), .SETTLE_FRAMES(0),
                  .TIMEOUT_CYCLES(TO), .FCNT_BITS(FW)) u_s0 (
    .pclk(pclk), .rst_n(rst_n), .in_vsync(in_vsync), .cfg_req(cfg_req),
    .cfg_thr(cfg_thr), .cfg_nr(cfg_nr), .cfg_dpc_byp(cfg_dpc_byp),
    .cfg_bnr_byp(cfg_bnr_byp), .cfg_busy(busy[1]), .cfg_ack(ack[1]),
    .dpc_threshold(thr[1]), .bnr_nr_level(nr[1]), .dpc_bypass(dbyp[1]),
    .bnr_bypass(bbyp[1]), .out_mask(mask[1]), .frame_start(fs[1]),
    .frame_cnt(fc[1]), .vs_timeout(tof[1]));

  // Expected life of one accepted request, in input-slot / observation cycles.
  typedef struct {
    int      c;       // capture slot
    int      e;       // commit cycle (HUGE if never)
    int      a;       // ack cycle (HUGE if never)
    int      r;       // reset cycle that kills it
    bit      killed;
    bit      to;
    bit [TW-1:0] thr;
    bit [NW-1:0] nr;
    bit      db, bb;
  } txn_t;

  txn_t sb [2][$];

  bit          vs_a [N];
  bit          rst_a [N];
  bit          req_a [N];
  bit [TW-1:0] thr_a [N];
  bit [NW-1:0] nr_a [N];
  bit          db_a [N], bb_a [N];

  int checks = 0, failures = 0;
  int free_from [2];
  int settle_of [2] = '{2, 0};

  // Expected live/sticky state per instance.
  bit [TW-1:0] e_thr [2];
  bit [NW-1:0] e_nr [2];
  bit          e_db [2], e_bb [2], e_to [2];
  int          e_fc [2];

  // Frame boundary as seen at slot k: rising vsync, history cleared by reset.
  function automatic bit edge_at(int k);
    if (k <= 0 || k >= N) return 1'b0;
    return rst_a[k] && vs_a[k] && !(rst_a[k-1] && vs_a[k-1]);
  endfunction

  function automatic txn_t predict(int s, int c);
    txn_t t;
    bit   done_commit = 1'b0;
    int   cnt = 0;
    t.c = c; t.e = HUGE; t.a = HUGE; t.r = HUGE; t.killed = 1'b0; t.to = 1'b0;
    t.thr = thr_a[c]; t.nr = nr_a[c]; t.db = db_a[c]; t.bb = bb_a[c];
    for (int p = c + 1; p < N; p++) begin
      if (!rst_a[p]) begin t.killed = 1'b1; t.r = p; return t; end
      if (!done_commit) begin
        if (edge_at(p) || p == c + TO) begin
          t.e = p; t.to = !edge_at(p); done_commit = 1'b1; cnt = s;
        end
      end else if (cnt == 0) begin
        t.a = p; return t;
      end else if (edge_at(p)) begin
        cnt--;
      end
    end
    return t;
  endfunction

  task automatic gen();
    int k, len, e99;
    for (int i = 0; i < N; i++) begin
      rst_a[i] = (i >= 4); vs_a[i] = 1'b0; req_a[i] = 1'b0;
      thr_a[i] = TW'($urandom); nr_a[i] = NW'($urandom_range(0, 4));
      db_a[i] = 1'($urandom); bb_a[i] = 1'($urandom);
    end
    for (int i = 0; i < 6; i++) begin
      k = $urandom_range(1000, N - 1000);
      rst_a[k] = 1'b0; rst_a[k+1] = 1'b0;
    end
    k = 0;
    while (k < N) begin
      if (k > N - 800)             len = 40;
      else if ($urandom % 7 == 0)  len = $urandom_range(150, 260);
      else                         len = $urandom_range(20, 90);
      for (int j = 0; j < len && k + j < N; j++) vs_a[k+j] = (j < 3);
      k += len;
    end
    for (int i = 6; i < N - 700; i++) begin
      if (i >= 290 && i < 800) continue;
      if ($urandom % 25 == 0) req_a[i] = 1'b1;
      if (edge_at(i) && ($urandom % 4 == 0)) req_a[i] = 1'b1;
    end
    req_a[300] = 1'b1; thr_a[300] = 40; nr_a[300] = 2; db_a[300] = 0; bb_a[300] = 0;
    e99 = 301;
    while (e99 < 700 && !edge_at(e99)) e99++;
    req_a[e99+1] = 1'b1; thr_a[e99+1] = 99;
  endtask

  task automatic cmp(int d, int k, string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s inst%0d cycle %0d: got %0d expected %0d", nm, d, k, act, exp);
    end
  endtask

  // Driver: applies slot k, and for each accepted request pushes its prediction.
  initial begin
    txn_t t;
    gen();
    free_from[0] = 0; free_from[1] = 0;
    for (int k = 0; k < N; k++) begin
      rst_n = rst_a[k]; in_vsync = vs_a[k]; cfg_req = req_a[k];
      cfg_thr = thr_a[k]; cfg_nr = nr_a[k];
      cfg_dpc_byp = db_a[k]; cfg_bnr_byp = bb_a[k];
      if (req_a[k] && rst_a[k]) begin
        for (int d = 0; d < 2; d++) begin
          if (k >= free_from[d]) begin
            t = predict(settle_of[d], k);
            sb[d].push_back(t);
            if (t.killed)         free_from[d] = t.r + 1;
            else if (t.a == HUGE) free_from[d] = HUGE;
            else                  free_from[d] = t.a + 1;
          end
        end
      end
      @(posedge pclk); #2;
    end
  end

  task automatic check_inst(int d, int k);
    txn_t t;
    bit   act, x_busy, x_mask, x_ack, x_fs;
    int   endc;
    x_busy = 0; x_mask = 0; x_ack = 0; x_fs = 0;
    if (!rst_a[k]) begin
      e_thr[d] = '0; e_nr[d] = '0; e_db[d] = 0; e_bb[d] = 0; e_to[d] = 0; e_fc[d] = 0;
    end else begin
      x_fs = edge_at(k);
      if (x_fs) e_fc[d] = (e_fc[d] + 1) % (1 << FW);
    end
    act = (sb[d].size() > 0) && (sb[d][0].c <= k);
    if (act) begin
      t = sb[d][0];
      endc   = t.killed ? t.r : t.a;
      x_busy = (k < endc);
      x_mask = (k >= t.e) && (k < endc);
      x_ack  = !t.killed && (k == t.a);
      if (k == t.e) begin
        e_thr[d] = t.thr; e_nr[d] = t.nr; e_db[d] = t.db; e_bb[d] = t.bb;
        if (t.to) e_to[d] = 1'b1;
      end
      if (k >= endc) void'(sb[d].pop_front());
    end
    cmp(d, k, "busy",        32'(busy[d]), 32'(x_busy));
    cmp(d, k, "ack",         32'(ack[d]),  32'(x_ack));
    cmp(d, k, "out_mask",    32'(mask[d]), 32'(x_mask));
    cmp(d, k, "threshold",   32'(thr[d]),  32'(e_thr[d]));
    cmp(d, k, "nr_level",    32'(nr[d]),   32'(e_nr[d]));
    cmp(d, k, "dpc_bypass",  32'(dbyp[d]), 32'(e_db[d]));
    cmp(d, k, "bnr_bypass",  32'(bbyp[d]), 32'(e_bb[d]));
    cmp(d, k, "frame_start", 32'(fs[d]),   32'(x_fs));
    cmp(d, k, "frame_cnt",   32'(fc[d]),   32'(e_fc[d]));
    cmp(d, k, "vs_timeout",  32'(tof[d]),  32'(e_to[d]));
  endtask

  // Monitor: observes every output mid-cycle and retires scoreboard entries.
  initial begin
    for (int k = 0; k < N; k++) begin
      @(posedge pclk); @(negedge pclk);
      for (int d = 0; d < 2; d++) check_inst(d, k);
    end
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (sb[d].size() != 0 && sb[d][0].a != HUGE) begin
        failures++;
        $display("FAIL drain inst%0d: got %0d open requests expected 0", d, sb[d].size());
      end
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
